// File: rtl/single_port_ram.sv
// Word-organised single-port synchronous RAM with a req/gnt/rvalid handshake and byte enables.
// A write to the mailbox word latches a sticky done flag and a pass/fail result bit.
module single_port_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 256,
    parameter int FLAG_ADDR  = NUM_WORDS - 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    port_req_i,
    input  logic [ADDR_WIDTH-1:0]   port_addr_i,
    input  logic                    port_we_i,
    input  logic [DATA_WIDTH-1:0]   port_wdata_i,
    input  logic                    en_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic                    port_gnt_o,
    output logic                    port_rvalid_o,
    output logic [DATA_WIDTH-1:0]   port_rdata_o,
    output logic                    mem_flag,
    output logic                    mem_result
);

    localparam int          NUM_BYTES   = DATA_WIDTH / 8;
    localparam logic [31:0] NUM_WORDS_U = 32'(NUM_WORDS);
    localparam logic [31:0] FLAG_ADDR_U = 32'(FLAG_ADDR);

    logic [DATA_WIDTH-1:0] mem [0:NUM_WORDS-1];

    logic        addr_in_range;
    logic        accept;
    logic        accept_wr;
    logic        accept_rd;
    logic        flag_hit;
    logic [31:0] addr_ext;

    // rst_n is active-high despite its name: grants are blocked while it is 1.
    assign port_gnt_o    = port_req_i & en_i & ~rst_n;
    assign accept        = port_gnt_o;
    assign accept_wr     = accept & port_we_i;
    assign accept_rd     = accept & ~port_we_i;
    assign addr_ext      = 32'(port_addr_i);
    assign addr_in_range = (addr_ext < NUM_WORDS_U);
    assign flag_hit      = (addr_ext == FLAG_ADDR_U);

    // Storage has no reset so preloaded program images survive a reset.
    always_ff @(posedge clk) begin
        if (accept_wr && addr_in_range) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (be_i[k]) begin
                    mem[port_addr_i][8*k +: 8] <= port_wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            port_rvalid_o <= 1'b0;
            port_rdata_o  <= '0;
            mem_flag      <= 1'b0;
            mem_result    <= 1'b0;
        end else begin
            port_rvalid_o <= accept;
            if (accept_rd) begin
                port_rdata_o <= addr_in_range ? mem[port_addr_i] : '0;
            end
            if (accept_wr && flag_hit && be_i[0]) begin
                mem_flag   <= 1'b1;
                mem_result <= port_wdata_i[0];
            end
        end
    end

endmodule

// File: tb/tb_single_port_ram.sv
// Directed self-checking bench for single_port_ram: reset, read sweep, writes, byte enables,
// enable gating and the mailbox flag/result outputs.
module tb_single_port_ram;

    logic        clk;
    logic        rst_n;
    logic        port_req_i;
    logic [7:0]  port_addr_i;
    logic        port_we_i;
    logic [31:0] port_wdata_i;
    logic        en_i;
    logic [3:0]  be_i;
    logic        port_gnt_o;
    logic        port_rvalid_o;
    logic [31:0] port_rdata_o;
    logic        mem_flag;
    logic        mem_result;

    int tests_run = 0;
    int tests_failed = 0;

    single_port_ram #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(32),
        .NUM_WORDS (256),
        .FLAG_ADDR (255)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .port_req_i   (port_req_i),
        .port_addr_i  (port_addr_i),
        .port_we_i    (port_we_i),
        .port_wdata_i (port_wdata_i),
        .en_i         (en_i),
        .be_i         (be_i),
        .port_gnt_o   (port_gnt_o),
        .port_rvalid_o(port_rvalid_o),
        .port_rdata_o (port_rdata_o),
        .mem_flag     (mem_flag),
        .mem_result   (mem_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge; grant is checked before the next edge.
    task automatic drive(input logic req, input logic we, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        port_req_i   = req;
        port_we_i    = we;
        port_addr_i  = addr;
        port_wdata_i = wdata;
        be_i         = be;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sweep_word(input int i);
        return 32'h0000_0013 + 32'(i) * 32'h0101_0100;
    endfunction

    logic [31:0] last_rdata;

    initial begin
        rst_n = 1'b1; en_i = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        tick; tick;
        rst_n = 1'b0;

        // preload through the port
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b1, 8'(8'h80 + 4*i), sweep_word(i), 4'hF);
            tick;
        end
        drive(1'b1, 1'b1, 8'h10, 32'h1122_3344, 4'hF); tick;
        drive(1'b1, 1'b1, 8'h20, 32'h5566_7788, 4'hF); tick;

        // make the registered outputs non-zero before reset
        drive(1'b1, 1'b1, 8'hFF, 32'h0000_0001, 4'h1); tick;
        chk("pre_rst_flag", 32'(mem_flag), 32'h1);
        drive(1'b1, 1'b0, 8'h10, 32'h0, 4'h0); tick;
        chk("pre_rst_rdata", port_rdata_o, 32'h1122_3344);

        // reset with a pending request
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, 8'h80, 32'h0, 4'h0);
            chk("rst_gnt", 32'(port_gnt_o), 32'h0);
            tick;
            chk("rst_rvalid", 32'(port_rvalid_o), 32'h0);
            chk("rst_rdata", port_rdata_o, 32'h0);
            chk("rst_flag", 32'(mem_flag), 32'h0);
            chk("rst_result", 32'(mem_result), 32'h0);
        end
        rst_n = 1'b0;

        // read sweep, one request every other cycle; first word checks memory survived reset
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 8'(8'h80 + 4*i), 32'h0, 4'h0);
            chk("sweep_gnt", 32'(port_gnt_o), 32'h1);
            tick;
            chk("sweep_rvalid", 32'(port_rvalid_o), 32'h1);
            chk("sweep_rdata", port_rdata_o, sweep_word(i));
            drive(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
            tick;
            chk("sweep_idle_rvalid", 32'(port_rvalid_o), 32'h0);
            chk("sweep_idle_hold", port_rdata_o, sweep_word(i));
        end
        last_rdata = sweep_word(31);

        // back-to-back full-word writes: rdata must not change
        for (int a = 8'hCC; a <= 8'hFC; a += 4) begin
            drive(1'b1, 1'b1, 8'(a), 32'h0000_BEEF, 4'hF);
            tick;
            chk("wr_rvalid", 32'(port_rvalid_o), 32'h1);
            chk("wr_rdata_hold", port_rdata_o, last_rdata);
        end
        for (int a = 8'hCC; a <= 8'hFC; a += 4) begin
            drive(1'b1, 1'b0, 8'(a), 32'h0, 4'h0);
            tick;
            chk("rd_beef_rvalid", 32'(port_rvalid_o), 32'h1);
            chk("rd_beef", port_rdata_o, 32'h0000_BEEF);
        end

        // read immediately after write to same address
        drive(1'b1, 1'b1, 8'h30, 32'hCAFE_F00D, 4'hF); tick;
        drive(1'b1, 1'b0, 8'h30, 32'h0, 4'h0); tick;
        chk("raw_b2b", port_rdata_o, 32'hCAFE_F00D);

        // byte enables 0101 over 0x11223344
        drive(1'b1, 1'b1, 8'h10, 32'hAABB_CCDD, 4'b0101); tick;
        drive(1'b1, 1'b0, 8'h10, 32'h0, 4'h0); tick;
        chk("byte_en", port_rdata_o, 32'h11BB_33DD);

        // enable gating
        en_i = 1'b0;
        drive(1'b1, 1'b1, 8'h20, 32'hFFFF_FFFF, 4'hF);
        chk("en0_gnt", 32'(port_gnt_o), 32'h0);
        tick;
        chk("en0_rvalid", 32'(port_rvalid_o), 32'h0);
        chk("en0_rdata_hold", port_rdata_o, 32'h11BB_33DD);
        en_i = 1'b1;
        drive(1'b1, 1'b0, 8'h20, 32'h0, 4'h0); tick;
        chk("en0_mem_kept", port_rdata_o, 32'h5566_7788);

        // mailbox
        drive(1'b1, 1'b1, 8'hFF, 32'h0000_0001, 4'b0001); tick;
        chk("mbox1_flag", 32'(mem_flag), 32'h1);
        chk("mbox1_result", 32'(mem_result), 32'h1);
        drive(1'b1, 1'b1, 8'hFF, 32'h0000_0000, 4'b0001); tick;
        chk("mbox0_flag", 32'(mem_flag), 32'h1);
        chk("mbox0_result", 32'(mem_result), 32'h0);
        drive(1'b1, 1'b1, 8'hFE, 32'h0000_0001, 4'b0001); tick;
        chk("mbox_fe_flag", 32'(mem_flag), 32'h1);
        chk("mbox_fe_result", 32'(mem_result), 32'h0);
        drive(1'b1, 1'b1, 8'hFF, 32'h0000_0001, 4'b1110); tick;
        chk("mbox_be0_result", 32'(mem_result), 32'h0);
        drive(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        rst_n = 1'b1;
        tick;
        chk("mbox_rst_flag", 32'(mem_flag), 32'h0);
        chk("mbox_rst_result", 32'(mem_result), 32'h0);
        rst_n = 1'b0;
        tick;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
